// File: rtl/sobel_pkg.sv
// Shared types and default geometry for the sobel window generator and the
// sobel kernel wrapper.
package sobel_pkg;

    typedef logic [7:0] pixel_t;

    localparam int IMG_WIDTH_DEF  = 352;
    localparam int IMG_HEIGHT_DEF = 288;

    // Row-major 3x3 neighbourhood, s11 = top-left (oldest row, oldest column).
    typedef struct packed {
        pixel_t s11;
        pixel_t s12;
        pixel_t s13;
        pixel_t s21;
        pixel_t s22;
        pixel_t s23;
        pixel_t s31;
        pixel_t s32;
        pixel_t s33;
    } window_t;

endpackage

// File: rtl/sobel_line_buffer.sv
// One image line of delay: read-before-write at the same index, so dout is
// the pixel written one line earlier at that column.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int DEPTH = IMG_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  pixel_t                   din,
    output pixel_t                   dout
);

    pixel_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= din;
        end
    end

    assign dout = mem[idx];

endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator: two chained line buffers plus a 3-column
// shift register that doubles as the single output register.
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_sof,
    input  logic [7:0]                    in_pixel,
    output logic                          win_valid,
    input  logic                          win_ready,
    output logic [7:0]                    s11,
    output logic [7:0]                    s12,
    output logic [7:0]                    s13,
    output logic [7:0]                    s21,
    output logic [7:0]                    s22,
    output logic [7:0]                    s23,
    output logic [7:0]                    s31,
    output logic [7:0]                    s32,
    output logic [7:0]                    s33,
    output logic [$clog2(IMG_HEIGHT)-1:0] win_row,
    output logic [$clog2(IMG_WIDTH)-1:0]  win_col,
    output logic                          win_last
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic          accept;
    logic          emit;
    logic [CW-1:0] col;
    logic [CW-1:0] cur_col;
    logic [RW-1:0] row;
    logic [RW-1:0] cur_row;
    pixel_t        top;
    pixel_t        mid;
    window_t       win_q;

    assign in_ready = !win_valid || win_ready;
    assign accept   = in_valid && in_ready;

    // An accepted start-of-frame pixel is (0,0) regardless of the counters.
    assign cur_col = in_sof ? '0 : col;
    assign cur_row = in_sof ? '0 : row;
    assign emit    = (cur_row >= RW'(2)) && (cur_col >= CW'(2));

    sobel_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb0 (
        .clk  (clk),
        .we   (accept),
        .idx  (cur_col),
        .din  (in_pixel),
        .dout (mid)
    );

    sobel_line_buffer #(.DEPTH(IMG_WIDTH)) u_lb1 (
        .clk  (clk),
        .we   (accept),
        .idx  (cur_col),
        .din  (mid),
        .dout (top)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col       <= '0;
            row       <= '0;
            win_q     <= '0;
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
        end else begin
            if (accept) begin
                win_q <= '{s11: win_q.s12, s12: win_q.s13, s13: top,
                           s21: win_q.s22, s22: win_q.s23, s23: mid,
                           s31: win_q.s32, s32: win_q.s33, s33: in_pixel};
                if (cur_col == COL_LAST) begin
                    col <= '0;
                    row <= (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
                end else begin
                    col <= cur_col + 1'b1;
                    row <= cur_row;
                end
            end
            // Window centre lags the newest pixel by one row and one column.
            if (accept && emit) begin
                win_valid <= 1'b1;
                win_row   <= cur_row - RW'(1);
                win_col   <= cur_col - CW'(1);
                win_last  <= (cur_row == ROW_LAST) && (cur_col == COL_LAST);
            end else if (win_ready) begin
                win_valid <= 1'b0;
            end
        end
    end

    assign s11 = win_q.s11;
    assign s12 = win_q.s12;
    assign s13 = win_q.s13;
    assign s21 = win_q.s21;
    assign s22 = win_q.s22;
    assign s23 = win_q.s23;
    assign s31 = win_q.s31;
    assign s32 = win_q.s32;
    assign s33 = win_q.s33;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench for sobel_window_gen on a 5x4 image: a frame-array model
// predicts windows, a monitor pops and compares each delivered window.
module tb_sobel_window_gen;

    localparam int W = 5;
    localparam int H = 4;

    typedef struct packed {
        logic [71:0] px;
        logic [1:0]  row;
        logic [2:0]  col;
        logic        last;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic       in_sof;
    logic [7:0] in_pixel;
    logic       win_valid;
    logic       win_ready;
    logic [7:0] s11, s12, s13, s21, s22, s23, s31, s32, s33;
    logic [1:0] win_row;
    logic [2:0] win_col;
    logic       win_last;

    int   checks = 0;
    int   fails  = 0;
    int   ready_mode = 0;
    exp_t q[$];
    logic [7:0] img [H][W];
    int   mrow = 0;
    int   mcol = 0;

    sobel_window_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sof    (in_sof),
        .in_pixel  (in_pixel),
        .win_valid (win_valid),
        .win_ready (win_ready),
        .s11       (s11),
        .s12       (s12),
        .s13       (s13),
        .s21       (s21),
        .s22       (s22),
        .s23       (s23),
        .s31       (s31),
        .s32       (s32),
        .s33       (s33),
        .win_row   (win_row),
        .win_col   (win_col),
        .win_last  (win_last)
    );

    always #5 clk = ~clk;

    function automatic exp_t actual();
        exp_t a;
        a.px   = {s11, s12, s13, s21, s22, s23, s31, s32, s33};
        a.row  = win_row;
        a.col  = win_col;
        a.last = win_last;
        return a;
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: store the frame as a 2D image, cut windows out of it.
    task automatic model_accept(input logic [7:0] pix, input logic sof, output bit produced);
        exp_t e;
        produced = 1'b0;
        if (sof) begin
            mrow = 0;
            mcol = 0;
        end
        img[mrow][mcol] = pix;
        if (mrow >= 2 && mcol >= 2) begin
            e.px = {img[mrow-2][mcol-2], img[mrow-2][mcol-1], img[mrow-2][mcol],
                    img[mrow-1][mcol-2], img[mrow-1][mcol-1], img[mrow-1][mcol],
                    img[mrow][mcol-2],   img[mrow][mcol-1],   img[mrow][mcol]};
            e.row  = 2'(mrow - 1);
            e.col  = 3'(mcol - 1);
            e.last = (mrow == H - 1) && (mcol == W - 1);
            q.push_back(e);
            produced = 1'b1;
        end
        mcol++;
        if (mcol == W) begin
            mcol = 0;
            mrow = (mrow + 1) % H;
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0 && win_valid === 1'b1 && win_ready === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_window: got %0h, expected none", actual());
            end else begin
                exp_t e;
                e = q.pop_front();
                check("window", 96'(actual()), 96'(e));
            end
        end
    end

    initial begin
        win_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       win_ready = 1'b1;
                1:       win_ready = 1'($urandom_range(0, 1));
                default: win_ready = 1'b0;
            endcase
        end
    end

    task automatic send(input logic [7:0] pix, input logic sof, input int gap);
        bit produced;
        bit ok;
        int n;
        in_valid = 1'b1;
        in_pixel = pix;
        in_sof   = sof;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else n++;
        end
        if (!ok) begin
            checks++;
            fails++;
            $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, expected 1", n);
        end else begin
            model_accept(pix, sof, produced);
        end
        @(posedge clk);
        #1;
        if (ok && produced) check("latency_win_valid", 96'(win_valid), 96'(1));
        in_valid = 1'b0;
        in_sof   = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] pat(input int p);
        return 8'((p / W) * 5 + (p % W));
    endfunction

    task automatic frame(input bit rnd, input int gapmode);
        for (int p = 0; p < W * H; p++) begin
            int g;
            g = (gapmode == 0) ? 0 : (gapmode == 1) ? 1 : int'($urandom_range(0, 2));
            send(rnd ? 8'($urandom) : pat(p), p == 0, g);
        end
    endtask

    task automatic drain();
        ready_mode = 0;
        repeat (12) @(posedge clk);
        #1;
        check("drain_queue_empty", 96'(q.size()), 96'(0));
    endtask

    initial begin
        exp_t first;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_pixel = 8'd0;
        repeat (2) @(negedge clk);
        check("reset_win_valid", 96'(win_valid), 96'(0));
        check("reset_outputs", 96'(actual()), 96'(0));
        check("reset_in_ready", 96'(in_ready), 96'(1));
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Full frame
        frame(0, 0);
        drain();

        // Backpressure at the first window
        for (int p = 0; p < 12; p++) send(pat(p), p == 0, 0);
        ready_mode = 2;
        win_ready  = 1'b0;
        send(pat(12), 1'b0, 0);
        first.px   = {8'd0, 8'd1, 8'd2, 8'd5, 8'd6, 8'd7, 8'd10, 8'd11, 8'd12};
        first.row  = 2'd1;
        first.col  = 3'd1;
        first.last = 1'b0;
        in_valid = 1'b1;
        in_pixel = pat(13);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", 96'(in_ready), 96'(0));
            check("stall_win_valid", 96'(win_valid), 96'(1));
            check("stall_window", 96'(actual()), 96'(first));
        end
        ready_mode = 0;
        for (int p = 13; p < W * H; p++) send(pat(p), 1'b0, 0);
        drain();

        // Gappy input
        frame(0, 1);
        drain();

        // Back-to-back frames
        for (int p = 0; p < 2 * W * H; p++) send(pat(p % (W * H)), (p % (W * H)) == 0, 0);
        drain();

        // Mid-frame asynchronous reset
        for (int p = 0; p < 14; p++) send(pat(p), p == 0, 0);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_win_valid", 96'(win_valid), 96'(0));
        check("async_reset_outputs", 96'(actual()), 96'(0));
        q.delete();
        mrow = 0;
        mcol = 0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        frame(0, 0);
        drain();

        // Aborted frame then resync with in_sof
        for (int p = 0; p < 8; p++) send(pat(p), p == 0, 0);
        frame(0, 0);
        drain();

        // Randomized pixels, gaps, backpressure and stray in_sof
        ready_mode = 1;
        repeat (4) frame(1, 2);
        ready_mode = 1;
        for (int p = 0; p < 60; p++)
            send(8'($urandom), ($urandom_range(0, 15) == 0), int'($urandom_range(0, 1)));
        drain();

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
- Streaming 3x3 neighbourhood generator that feeds the combinational sobel kernel.
- Accepts one 8-bit pixel per cycle in raster order and buffers two previous image lines.
- Emits one 3x3 window (s11..s33) for each interior pixel position; the first digit of each window port is the row (1 = top/oldest) and the second digit is the column (1 = left/oldest).
- Sits between the image-memory reader and the sobel instance.

Parameters:
IMG_WIDTH, 352, pixels per line (>= 3)
IMG_HEIGHT, 288, lines per frame (>= 3)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
in_valid  in  1  in_pixel valid
in_ready  out  1  block accepts in_pixel this cycle
in_sof  in  1  start of frame: this pixel is (row 0, col 0)
in_pixel  in  8  input pixel, raster order
win_valid  out  1  window outputs valid
win_ready  in  1  downstream accepts window
s11,s12,s13,s21,s22,s23,s31,s32,s33  out  8 each  3x3 window, row/col indexed
win_row  out  $clog2(IMG_HEIGHT)  row of window centre
win_col  out  $clog2(IMG_WIDTH)  column of window centre
win_last  out  1  last window of frame (centre = H-2, W-2)

Behaviour:
- Reset (async, active-high):
  - Outputs: win_valid=0, win_last=0, all s*=0, win_row=0, win_col=0.
  - Internal: col/row counters = 0, column shift registers cleared.
  - Line-buffer contents are don't-care.
- Flow control:
  - in_ready = !win_valid || win_ready, which gives a single output register with full throughput and no bubbles.
  - Accept = in_valid && in_ready. Only accepted pixels advance any state.
- Counters:
  - col increments per accept and wraps at IMG_WIDTH-1 -> 0 with row++.
  - row wraps at IMG_HEIGHT-1 -> 0, and the next frame starts seamlessly.
  - Accepted in_sof=1 forces the current pixel to (0,0) and counters continue from there. This abandons any partial frame; a window already held in the output register is still delivered.
- Line buffers:
  - Two lines, each IMG_WIDTH x 8, with combinational read at index col.
  - On accept: lb1[col] <= lb0[col]; lb0[col] <= in_pixel.
  - Taps this cycle: top = lb1[col], mid = lb0[col], bot = in_pixel.
- Column shift:
  - On accept, the three taps shift into the rightmost column: s13/s23/s33 <= top/mid/bot.
  - Old column 3 moves to column 2, old column 2 to column 1.
  - The s* registers are the outputs themselves, so they must not shift while the held window is stalled. in_ready=0 during a stall guarantees this.
- Window emission:
  - On accept of pixel (r,c) with r>=2 and c>=2: win_valid <= 1 next cycle, win_row <= r-1, win_col <= c-1, win_last <= (r==H-1 && c==W-1).
  - Latency: one cycle from the accept of the bottom-right pixel to win_valid.
  - Otherwise win_valid <= 0 when win_ready=1. When win_ready=0, valid and data hold.
- Output count: exactly (H-2)*(W-2) windows per frame; no border windows.
- Cross-line boundary: at c=0 and c=1 the column shift contains wrapped pixels from the previous line, but no window is emitted until c=2, so nothing wrapped is ever exposed.
- Stall: while win_valid && !win_ready, all outputs are stable and in_ready=0.
- Simultaneous win_ready and accept: the window is consumed and a new one is loaded in the same cycle.
- Arithmetic: counters are unsigned, with no other arithmetic.

Decomposition:
- sobel_pkg holds pixel_t (logic[7:0]), IMG_WIDTH_DEF/IMG_HEIGHT_DEF constants, and window_t (packed struct of 9 pixel_t), shared with the sobel wrapper.
- One sub-module, sobel_line_buffer: a single-line delay of IMG_WIDTH, with write-enable, index, din, and combinational dout. It is instantiated twice and chained.

Test Plan:
All scenarios use W=5, H=4, pixel value = r*5+c, in_valid=1 and win_ready=1 unless stated.
1. Full frame: exactly 6 windows. The first has win_row=1, win_col=1, s11..s33 = 0,1,2,5,6,7,10,11,12, and win_valid rises 1 cycle after pixel 12 is accepted. The last has centre (2,3), s = 7,8,9,12,13,14,17,18,19, win_last=1.
2. Backpressure: hold win_ready=0 for 5 cycles at the first window -> in_ready=0, outputs stable at 0,1,2,5,6,7,10,11,12. Release -> the next window is centre (1,2), s = 1,2,3,6,7,8,11,12,13, with no pixel lost.
3. Gappy input: in_valid toggles 1/0 each cycle -> the same 6 windows and values as scenario 1, none duplicated.
4. Back-to-back frames: 40 pixels sent, in_sof on pixels 0 and 20 -> 12 windows; window 7 equals window 1 (values +0, since the pixel pattern repeats).
5. Mid-frame reset: assert reset after pixel 13 -> win_valid=0 immediately (async). A new frame from (0,0) then yields the scenario-1 results.
6. in_sof resync: frame aborted after 8 pixels, then a full frame with in_sof -> exactly 6 windows, first window = 0,1,2,5,6,7,10,11,12.
